sine_lut: RTL and testbench



---
 rtl/sine_lut.sv | 72 +++++++
 tb/tb_sine_lut.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/sine_lut.sv
// Registered quarter-wave sine lookup: 2^AW-entry table over [0, pi/2), one-cycle latency.
// Define SINE_LUT_FULL_WAVE_EN to add the quad input and do quadrant folding/negation in here.
module sine_lut #(
    parameter int AW  = 13,
    parameter int DW  = 16,
    parameter int AMP = 32767
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [AW-1:0] v,
`ifdef SINE_LUT_FULL_WAVE_EN
    input  logic [1:0]    quad,
`endif
    output logic [DW-1:0] sv,
    output logic          sv_valid
);

    localparam int  DEPTH = 2 ** AW;
    localparam real PI    = 3.14159265358979323846;

    // Odd Taylor series to x^15 in Horner form; error is far below 1 LSB over [0, pi/2).
    // Adding 0.5 before truncation rounds half away from zero, since entries are non-negative.
    function automatic logic [DW-1:0] entry(input int k);
        real x;
        real x2;
        real s;
        int  r;
        x  = PI * real'(k) / (2.0 ** (AW + 1));
        x2 = x * x;
        s  = x * (1.0 - x2 / 6.0 * (1.0 - x2 / 20.0 * (1.0 - x2 / 42.0 *
             (1.0 - x2 / 72.0 * (1.0 - x2 / 110.0 * (1.0 - x2 / 156.0 *
             (1.0 - x2 / 210.0)))))));
        r  = $rtoi(real'(AMP) * s + 0.5);
        if (r > AMP) r = AMP;
        if (r < 0)   r = 0;
        return DW'(r);
    endfunction

    logic [DW-1:0] rom [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_rom
        localparam logic [DW-1:0] VALUE = entry(k);
        assign rom[k] = VALUE;
    end

    logic [AW-1:0] idx;
    logic [DW-1:0] next_sv;

    always_comb begin
        idx     = v;
        next_sv = '0;
`ifdef SINE_LUT_FULL_WAVE_EN
        // Odd quadrants run the quarter wave backwards; the lower half-cycle is negated.
        if (quad[0]) idx = ~v;
        next_sv = quad[1] ? -rom[idx] : rom[idx];
`else
        next_sv = rom[idx];
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sv       <= '0;
            sv_valid <= 1'b0;
        end else begin
            sv_valid <= en;
            if (en) sv <= next_sv;
        end
    end

endmodule

// File: tb/tb_sine_lut.sv
// Scoreboard bench for sine_lut: driver pushes one expectation per clock edge, a negedge
// monitor pops and compares; the reference uses $sin directly.
module tb_sine_lut;

    localparam int  AW  = 13;
    localparam int  DW  = 16;
    localparam int  AMP = 32767;
    localparam real PI  = 3.14159265358979323846;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [AW-1:0] v;
    logic [1:0]    quad;
    logic [DW-1:0] sv;
    logic          sv_valid;

    always #5 clk = ~clk;

    sine_lut #(.AW(AW), .DW(DW), .AMP(AMP)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .v        (v),
`ifdef SINE_LUT_FULL_WAVE_EN
        .quad     (quad),
`endif
        .sv       (sv),
        .sv_valid (sv_valid)
    );

    typedef struct {
        bit valid;
        int val;
        int tol;
        bit mono;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   passed   = 0;
    int   hold_val = 0;
    int   hold_tol = 0;
    int   prev_sv  = 0;

    function automatic int model(input int idx_in, input int q);
        int  k;
        int  mag;
        real m;
        k   = (q % 2 == 1) ? (2 ** AW - 1 - idx_in) : idx_in;
        m   = real'(AMP) * $sin(PI * real'(k) / (2.0 ** (AW + 1)));
        mag = $rtoi(m + 0.5);
        return (q >= 2) ? -mag : mag;
    endfunction

    task automatic check(input string name, input bit ok, input int act, input int req);
        checks++;
        if (ok) passed++;
        else $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    endtask

    task automatic drive(input bit r, input bit e, input int vi, input int q, input bit mono);
        exp_t x;
        @(negedge clk);
        #1;
        rst  = r;
        en   = e;
        v    = AW'(vi);
        quad = 2'(q);
        @(posedge clk);
        if (r) begin
            hold_val = 0;
            hold_tol = 0;
            x = '{valid: 1'b0, val: 0, tol: 0, mono: 1'b0};
        end else if (e) begin
            x.valid  = 1'b1;
            x.val    = model(vi, q);
            x.tol    = (x.val == 0 || x.val == AMP || x.val == -AMP) ? 0 : 1;
            x.mono   = mono;
            hold_val = x.val;
            hold_tol = x.tol;
        end else begin
            x = '{valid: 1'b0, val: hold_val, tol: hold_tol, mono: 1'b0};
        end
        exp_q.push_back(x);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            int   act;
            int   diff;
            e    = exp_q.pop_front();
            act  = int'($signed(sv));
            diff = act - e.val;
            if (diff < 0) diff = -diff;
            check("sv_valid", sv_valid === e.valid, int'(sv_valid), int'(e.valid));
            check(e.valid ? "sv_value" : "sv_hold", !$isunknown(sv) && diff <= e.tol, act, e.val);
            if (e.mono) check("monotonic", act >= prev_sv, act, prev_sv);
            if (e.valid) prev_sv = act;
        end
    end

    initial begin
        rst  = 1'b1;
        en   = 1'b0;
        v    = '0;
        quad = 2'b00;

        // Reset wins over en; then idle keeps zero.
        drive(1, 1, 8191, 0, 0);
        drive(1, 1, 8191, 0, 0);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);

        // Key points.
        drive(0, 1, 0, 0, 0);
        drive(0, 1, 2048, 0, 0);
        drive(0, 1, 4096, 0, 0);
        drive(0, 1, 8191, 0, 0);
        drive(0, 0, 0, 0, 0);

        // Back-to-back stream, then hold.
        for (int i = 0; i <= 4; i++) drive(0, 1, i * 1024, 0, 0);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 5, 0, 0);

        // Full sweep, monotonic.
        for (int i = 0; i < 2 ** AW; i++) drive(0, 1, i, 0, i > 0);

        // Reset mid-stream discards the pending lookup.
        drive(0, 1, 1000, 0, 0);
        drive(1, 1, 4096, 0, 0);
        drive(0, 1, 8191, 0, 0);
        drive(0, 0, 0, 0, 0);

`ifdef SINE_LUT_FULL_WAVE_EN
        drive(0, 1, 4096, 2, 0);
        drive(0, 1, 0, 1, 0);
        drive(0, 1, 8191, 3, 0);
        drive(0, 1, 8191, 0, 0);
        drive(0, 0, 0, 0, 0);
`endif

        // Random traffic with sporadic resets.
        for (int i = 0; i < 300; i++) begin
            int q;
            q = 0;
`ifdef SINE_LUT_FULL_WAVE_EN
            q = int'($urandom_range(0, 3));
`endif
            drive($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0,
                  int'($urandom_range(0, 2 ** AW - 1)), q, 0);
        end

        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        check("drain", exp_q.size() == 0, exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
